// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Handles branch/jump redirects, decode stalls, and stops at the end of the program image.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          PROG_WORDS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] imInstruction,
    output logic [31:0] imAddress,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pcPlus4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  RUN        = 1'b0;
    localparam logic [0:0]  HALTED     = 1'b1;
    localparam logic [31:0] PROG_LIMIT = PROG_WORDS[31:0];

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        end_of_prog;
    logic        unused_bits;

    // Branch target is forced to word alignment; its low bits are intentionally dropped.
    assign unused_bits     = &{1'b0, branch_target[1:0]};

    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? {branch_target[31:2], 2'b00}
                                          : {ifid_pcPlus4[31:28], jump_index, 2'b00};
    assign pc_plus4        = pc + 32'd4;
    assign end_of_prog     = {2'b00, pc[31:2]} >= PROG_LIMIT;

    assign imAddress = pc;
    assign halted    = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= RUN;
            pc               <= RESET_PC;
            ifid_instruction <= 32'h0000_0000;
            ifid_pcPlus4     <= 32'h0000_0000;
            ifid_valid       <= 1'b0;
            fetch_count      <= 32'h0000_0000;
        end else if (state == RUN) begin
            // Priority: redirect, then stall, then end-of-program, then a normal fetch.
            if (redirect) begin
                pc               <= redirect_target;
                ifid_instruction <= 32'h0000_0000;
                ifid_pcPlus4     <= 32'h0000_0000;
                ifid_valid       <= 1'b0;
            end else if (stall) begin
                pc <= pc;
            end else if (end_of_prog) begin
                state            <= HALTED;
                ifid_instruction <= 32'h0000_0000;
                ifid_pcPlus4     <= 32'h0000_0000;
                ifid_valid       <= 1'b0;
            end else begin
                pc               <= pc_plus4;
                ifid_instruction <= imInstruction;
                ifid_pcPlus4     <= pc_plus4;
                ifid_valid       <= 1'b1;
                fetch_count      <= fetch_count + 32'd1;
            end
        end else begin
            // Halted: only reset leaves this state, so keep IF/ID as a bubble.
            ifid_instruction <= 32'h0000_0000;
            ifid_pcPlus4     <= 32'h0000_0000;
            ifid_valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch with a combinational instruction-memory model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] im_instruction;
    logic [31:0] im_address;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int n_compared = 0;
    int n_mismatched = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .PROG_WORDS(30)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_index       (jump_index),
        .imInstruction    (im_instruction),
        .imAddress        (im_address),
        .ifid_instruction (ifid_instruction),
        .ifid_pcPlus4     (ifid_pc_plus4),
        .ifid_valid       (ifid_valid),
        .halted           (halted),
        .fetch_count      (fetch_count)
    );

    always #5 clk = ~clk;

    // Word 2 holds a real instruction; every other word is 0xA000_0000 | word index.
    assign im_instruction = (im_address == 32'h8) ? 32'h0109_8024
                                                  : (32'hA000_0000 | (im_address >> 2));

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        jmp;
        logic [25:0] jidx;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_p4;
        logic        e_valid;
        logic        e_halt;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic j, logic [25:0] ji,
                                logic [31:0] ea, logic [31:0] ei, logic [31:0] ep,
                                logic ev, logic eh, logic [31:0] ef);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.jmp = j; v.jidx = ji;
        v.e_addr = ea; v.e_instr = ei; v.e_p4 = ep; v.e_valid = ev; v.e_halt = eh; v.e_fc = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t,
                         input logic j, input logic [25:0] ji);
        stall = s; branch_taken = b; branch_target = t; jump = j; jump_index = ji;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                             input logic [31:0] ep, input logic ev, input logic eh,
                             input logic [31:0] ef);
        chk({tag, ".imAddress"}, im_address, ea);
        chk({tag, ".ifid_instruction"}, ifid_instruction, ei);
        chk({tag, ".ifid_pcPlus4"}, ifid_pc_plus4, ep);
        chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, ev});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, eh});
        chk({tag, ".fetch_count"}, fetch_count, ef);
    endtask

    initial begin
        //               stall br  tgt           jmp jidx    addr          instr         p4            v     h     fc
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h04, 32'hA000_0000, 32'h04, 1'b1, 1'b0, 32'd1);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h08, 32'hA000_0001, 32'h08, 1'b1, 1'b0, 32'd2);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h0C, 32'h0109_8024, 32'h0C, 1'b1, 1'b0, 32'd3);
        vecs[3]  = mk(1'b0, 1'b1, 32'h4A, 1'b0, 26'h0,  32'h48, 32'h0,         32'h0,  1'b0, 1'b0, 32'd3);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h4C, 32'hA000_0012, 32'h4C, 1'b1, 1'b0, 32'd4);
        vecs[5]  = mk(1'b0, 1'b1, 32'h47, 1'b0, 26'h0,  32'h44, 32'h0,         32'h0,  1'b0, 1'b0, 32'd4);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h48, 32'hA000_0011, 32'h48, 1'b1, 1'b0, 32'd5);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 26'h0E, 32'h38, 32'h0,         32'h0,  1'b0, 1'b0, 32'd5);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h3C, 32'hA000_000E, 32'h3C, 1'b1, 1'b0, 32'd6);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 26'h0,  32'h3C, 32'hA000_000E, 32'h3C, 1'b1, 1'b0, 32'd6);
        vecs[10] = mk(1'b1, 1'b0, 32'h0,  1'b0, 26'h0,  32'h3C, 32'hA000_000E, 32'h3C, 1'b1, 1'b0, 32'd6);
        vecs[11] = mk(1'b1, 1'b0, 32'h0,  1'b1, 26'h1F, 32'h7C, 32'h0,         32'h0,  1'b0, 1'b0, 32'd6);
        vecs[12] = mk(1'b0, 1'b1, 32'h20, 1'b1, 26'h1F, 32'h20, 32'h0,         32'h0,  1'b0, 1'b0, 32'd6);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,  1'b1, 26'h1F, 32'h7C, 32'h0,         32'h0,  1'b0, 1'b0, 32'd6);
        vecs[14] = mk(1'b1, 1'b0, 32'h0,  1'b0, 26'h0,  32'h7C, 32'h0,         32'h0,  1'b0, 1'b0, 32'd6);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,  1'b0, 26'h0,  32'h7C, 32'h0,         32'h0,  1'b0, 1'b1, 32'd6);
        vecs[16] = mk(1'b1, 1'b1, 32'h10, 1'b1, 26'h3,  32'h7C, 32'h0,         32'h0,  1'b0, 1'b1, 32'd6);
        vecs[17] = mk(1'b0, 1'b0, 32'h0,  1'b1, 26'h3,  32'h7C, 32'h0,         32'h0,  1'b0, 1'b1, 32'd6);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        step();
        step();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].jmp, vecs[i].jidx);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_p4,
                      vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_fc);
        end

        // Asynchronous reset while halted, asserted midway between edges.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        step();
        check_all("rst_held", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        // Last valid word (29) is fetched; word 30 triggers the halt.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 26'h1D);
        step();
        check_all("jump_w29", 32'h74, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        step();
        check_all("fetch_w29", 32'h78, 32'hA000_001D, 32'h78, 1'b1, 1'b0, 32'd1);
        step();
        check_all("halt_w30", 32'h78, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PROG_WORDS, default 30: number of valid instruction words; word index >= PROG_WORDS marks end of program.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-006 branch_taken  input  1  resolved taken branch from decode.
REQ-007 branch_target  input  32  branch destination byte address.
REQ-008 jump  input  1  jump resolved in decode.
REQ-009 jump_index  input  26  jump instruction index field.
REQ-010 imInstruction  input  32  instruction word returned combinationally by instruction memory for imAddress.
REQ-011 imAddress  output  32  current PC, driven to instruction memory.
REQ-012 ifid_instruction  output  32  registered instruction for decode.
REQ-013 ifid_pcPlus4  output  32  registered PC+4 of that instruction.
REQ-014 ifid_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-015 halted  output  1  fetch has stopped at end of program.
REQ-016 fetch_count  output  32  number of instructions delivered into IF/ID.

Function
REQ-017 imAddress SHALL equal the PC register combinationally; no extra latency.
REQ-018 State machine SHALL have two states, RUN and HALTED; halted = (state == HALTED).
REQ-019 Redirect = branch_taken | jump; when both are high, branch_taken SHALL win.
REQ-020 Branch target SHALL be {branch_target[31:2], 2'b00}; misaligned low bits are discarded.
REQ-021 Jump target SHALL be {ifid_pcPlus4[31:28], jump_index, 2'b00}.
REQ-022 In RUN, each rising edge SHALL apply the first matching rule, in this priority order:
- (a) redirect: PC <= target; IF/ID <= bubble; fetch_count unchanged.
- (b) stall: PC, IF/ID and fetch_count hold.
- (c) PC>>2 >= PROG_WORDS: state <= HALTED; PC holds; IF/ID <= bubble.
- (d) otherwise: IF/ID <= {imInstruction, PC+4, valid=1}; PC <= PC+4; fetch_count += 1.
REQ-023 Redirect SHALL override a simultaneous stall (rule a beats rule b).
REQ-024 Bubble SHALL mean ifid_instruction = 32'h0000_0000 (nop), ifid_pcPlus4 = 0, ifid_valid = 0.
REQ-025 In HALTED, PC SHALL hold, IF/ID SHALL stay bubble, and stall and redirect SHALL be ignored; only reset exits HALTED.
REQ-026 PC+4 and fetch_count SHALL wrap modulo 2^32 without flags.
REQ-027 Instruction latency SHALL be one cycle: the word at PC appears on ifid_instruction after the next rising edge.

Reset
REQ-028 On rst_n low, independent of clk, outputs SHALL immediately become: PC = RESET_PC, state = RUN, IF/ID = bubble, halted = 0, fetch_count = 0.
REQ-029 Reset asserted mid-operation, including during stall, redirect or HALTED, SHALL discard all in-flight state.
REQ-030 The first fetch SHALL occur on the first rising edge with rst_n high.

Verification
REQ-031 Basic fetch: release reset, no stall, three edges -> ifid_instruction = 32'h01098024, ifid_pcPlus4 = 32'h0C, imAddress = 32'h0C, fetch_count = 3.
REQ-032 Branch redirect: branch_taken = 1 with branch_target = 32'h4A for one edge -> imAddress = 32'h48, ifid_valid = 0, fetch_count unchanged.
REQ-033 Jump: ifid_pcPlus4 = 32'h48, jump = 1, jump_index = 26'h0E -> imAddress = 32'h38.
REQ-034 Stall vs redirect: stall = 1 for 2 edges -> imAddress and IF/ID unchanged; stall = 1 together with jump_index = 26'h1F and jump = 1 -> imAddress = 32'h7C.
REQ-035 End of program: imAddress = 32'h7C (word 31 >= 30), next edge -> halted = 1, ifid_valid = 0; then any further stall or redirect -> no change.
REQ-036 Async reset: drive rst_n low between clock edges while halted -> imAddress = 0, halted = 0, fetch_count = 0 before the next edge.
